// File: rtl/counter_arbiter_ctrl.sv
// Round-robin arbiter in front of a 2-bit up/down counter: grants requester A or B,
// then steps the counter exactly len times in the captured direction.
module counter_arbiter_ctrl #(
   parameter int LEN_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req_a,
   input  logic             dir_a,
   input  logic [LEN_W-1:0] len_a,
   output logic             ack_a,
   output logic             done_a,
   input  logic             req_b,
   input  logic             dir_b,
   input  logic [LEN_W-1:0] len_b,
   output logic             ack_b,
   output logic             done_b,
   output logic [1:0]       q,
   output logic             busy,
   output logic             owner
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state_reg, state_next;
   logic [1:0]       q_reg, q_next;
   logic             last_reg, last_next;
   logic             owner_reg, owner_next;
   logic             dir_reg, dir_next;
   logic [LEN_W-1:0] rem_reg, rem_next;
   logic             ack_a_reg, ack_a_next;
   logic             ack_b_reg, ack_b_next;
   logic             done_a_reg, done_a_next;
   logic             done_b_reg, done_b_next;
   logic             busy_reg, busy_next;
   logic             grant_b;
   logic [LEN_W-1:0] len_sel;

   // B wins when it is alone, or when both ask and A was served last.
   assign grant_b = req_b & (~req_a | ~last_reg);
   assign len_sel = grant_b ? len_b : len_a;

   always_comb begin
      state_next  = state_reg;
      q_next      = q_reg;
      last_next   = last_reg;
      owner_next  = owner_reg;
      dir_next    = dir_reg;
      rem_next    = rem_reg;
      ack_a_next  = 1'b0;
      ack_b_next  = 1'b0;
      case (state_reg)
         IDLE: begin
            if (req_a || req_b) begin
               owner_next = grant_b;
               dir_next   = grant_b ? dir_b : dir_a;
               rem_next   = len_sel;
               ack_a_next = ~grant_b;
               ack_b_next = grant_b;
               state_next = (len_sel != '0) ? RUN : DONE;
            end
         end
         RUN: begin
            q_next   = dir_reg ? (q_reg - 2'd1) : (q_reg + 2'd1);
            rem_next = rem_reg - 1'b1;
            if (rem_reg == {{(LEN_W-1){1'b0}}, 1'b1}) begin
               state_next = DONE;
            end
         end
         DONE: begin
            last_next  = owner_reg;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
      // DONE lasts exactly one cycle, so entering it is the done pulse.
      done_a_next = (state_next == DONE) && !owner_next;
      done_b_next = (state_next == DONE) && owner_next;
      busy_next   = (state_next != IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg  <= IDLE;
         q_reg      <= 2'd0;
         last_reg   <= 1'b1;
         owner_reg  <= 1'b0;
         dir_reg    <= 1'b0;
         rem_reg    <= '0;
         ack_a_reg  <= 1'b0;
         ack_b_reg  <= 1'b0;
         done_a_reg <= 1'b0;
         done_b_reg <= 1'b0;
         busy_reg   <= 1'b0;
      end else begin
         state_reg  <= state_next;
         q_reg      <= q_next;
         last_reg   <= last_next;
         owner_reg  <= owner_next;
         dir_reg    <= dir_next;
         rem_reg    <= rem_next;
         ack_a_reg  <= ack_a_next;
         ack_b_reg  <= ack_b_next;
         done_a_reg <= done_a_next;
         done_b_reg <= done_b_next;
         busy_reg   <= busy_next;
      end
   end

   assign q      = q_reg;
   assign busy   = busy_reg;
   assign owner  = owner_reg;
   assign ack_a  = ack_a_reg;
   assign ack_b  = ack_b_reg;
   assign done_a = done_a_reg;
   assign done_b = done_b_reg;

endmodule

// File: tb/tb_counter_arbiter_ctrl.sv
// Bench for counter_arbiter_ctrl: directed scenarios plus random traffic, checked every
// cycle against a run-timeline model (cycles elapsed since the grant).
module tb_counter_arbiter_ctrl;
   localparam int LEN_W = 4;

   logic             clk = 1'b0;
   logic             rst;
   logic             req_a, dir_a, req_b, dir_b;
   logic [LEN_W-1:0] len_a, len_b;
   logic             ack_a, done_a, ack_b, done_b, busy, owner;
   logic [1:0]       q;

   counter_arbiter_ctrl #(.LEN_W(LEN_W)) dut (
      .clk(clk), .rst(rst),
      .req_a(req_a), .dir_a(dir_a), .len_a(len_a), .ack_a(ack_a), .done_a(done_a),
      .req_b(req_b), .dir_b(dir_b), .len_b(len_b), .ack_b(ack_b), .done_b(done_b),
      .q(q), .busy(busy), .owner(owner)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int errs  = 0;

   // Model: a run is a timeline t = 0 (grant edge) .. len+1 (back to idle).
   bit       m_act;
   int       m_t, m_len;
   bit       m_dir, m_own, m_last;
   bit [1:0] m_q;
   bit       e_ack_a, e_ack_b, e_done_a, e_done_b, e_busy;

   task automatic chk(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         errs++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_edge();
      if (rst) begin
         m_act = 0; m_q = 0; m_last = 1; m_own = 0;
         e_ack_a = 0; e_ack_b = 0; e_done_a = 0; e_done_b = 0; e_busy = 0;
      end else if (!m_act) begin
         e_ack_a = 0; e_ack_b = 0; e_done_a = 0; e_done_b = 0;
         if (req_a || req_b) begin
            m_own = (req_a && req_b) ? !m_last : req_b;
            m_len = m_own ? int'(len_b) : int'(len_a);
            m_dir = m_own ? dir_b : dir_a;
            m_act = 1; m_t = 0;
            e_ack_a = !m_own; e_ack_b = m_own;
            e_done_a = (m_len == 0) && !m_own;
            e_done_b = (m_len == 0) && m_own;
         end
         e_busy = m_act;
      end else begin
         m_t++;
         e_ack_a = 0; e_ack_b = 0;
         if (m_t <= m_len) m_q = m_dir ? m_q - 2'd1 : m_q + 2'd1;
         e_done_a = (m_t == m_len) && !m_own;
         e_done_b = (m_t == m_len) && m_own;
         if (m_t == m_len + 1) begin
            m_act = 0; m_last = m_own;
         end
         e_busy = m_act;
      end
   endtask

   // One clock: model advances on the same inputs the DUT samples, then compare.
   task automatic cyc();
      @(posedge clk);
      model_edge();
      #1;
      chk("q", q, m_q);
      chk("busy", busy, e_busy);
      chk("owner", owner, m_own);
      chk("ack_a", ack_a, e_ack_a);
      chk("ack_b", ack_b, e_ack_b);
      chk("done_a", done_a, e_done_a);
      chk("done_b", done_b, e_done_b);
   endtask

   task automatic wait_done(input bit which_b, input string name);
      bit seen = 0;
      for (int i = 0; i < 40 && !seen; i++) begin
         cyc();
         seen = which_b ? done_b : done_a;
      end
      if (!seen) chk({name, "_timeout"}, 0, 1);
   endtask

   int acks_seen;
   bit [3:0] ack_owners;

   initial begin
      rst = 1; req_a = 1; dir_a = 0; len_a = 5; req_b = 0; dir_b = 0; len_b = 0;
      // Reset held two cycles with A requesting: nothing may happen.
      cyc();
      cyc();
      chk("rst_busy", busy, 0);
      chk("rst_ack_a", ack_a, 0);
      chk("rst_q", q, 0);
      rst = 0;
      cyc();
      chk("a_ack_after_rst", ack_a, 1);
      req_a = 0;
      cyc(); cyc(); cyc();
      chk("a_q_after_3", q, 3);
      wait_done(0, "a_run");
      chk("a_final_q", q, 1);
      cyc(); cyc();
      chk("a_idle_busy", busy, 0);

      // B alone, counting down three from q=1.
      req_b = 1; dir_b = 1; len_b = 3;
      cyc();
      chk("b_ack", ack_b, 1);
      req_b = 0;
      wait_done(1, "b_run");
      chk("b_final_q", q, 2);
      chk("b_owner", owner, 1);
      cyc();

      // Both requesting continuously: grants alternate A,B,A,B.
      req_a = 1; req_b = 1; len_a = 2; len_b = 2; dir_a = 0; dir_b = 1;
      acks_seen = 0;
      for (int i = 0; i < 30 && acks_seen < 4; i++) begin
         cyc();
         if (ack_a || ack_b) begin
            ack_owners[acks_seen] = ack_b;
            acks_seen++;
         end
      end
      chk("rr_ack_count", acks_seen, 4);
      chk("rr_order", ack_owners, 4'b1010);
      req_a = 0; req_b = 0;
      for (int i = 0; i < 6; i++) cyc();

      // Zero-length run: ack and done together, q untouched.
      req_a = 1; len_a = 0;
      cyc();
      chk("z_ack", ack_a, 1);
      chk("z_done", done_a, 1);
      chk("z_q", q, 2);
      req_a = 0;
      cyc();
      chk("z_busy", busy, 0);
      cyc();

      // Reset during a long run aborts it; A then wins the next contest.
      req_a = 1; len_a = 7; dir_a = 0;
      cyc();
      req_a = 0;
      cyc(); cyc();
      rst = 1;
      cyc();
      rst = 0;
      chk("ab_q", q, 0);
      chk("ab_busy", busy, 0);
      chk("ab_done", done_a, 0);
      req_a = 1; req_b = 1; len_a = 1; len_b = 1;
      cyc();
      chk("ab_regrant_a", ack_a, 1);
      req_a = 0; req_b = 0;
      for (int i = 0; i < 4; i++) cyc();

      // Random traffic including occasional reset.
      for (int i = 0; i < 3000; i++) begin
         rst   = ($urandom_range(0, 199) == 0);
         req_a = $urandom_range(0, 2) != 0;
         req_b = $urandom_range(0, 2) != 0;
         dir_a = 1'($urandom);
         dir_b = 1'($urandom);
         len_a = ($urandom_range(0, 5) == 0) ? '0 : LEN_W'($urandom);
         len_b = ($urandom_range(0, 5) == 0) ? '0 : LEN_W'($urandom);
         cyc();
      end

      $display("[TB] %0d tests run, %0d failed", tests, errs);
      $finish;
   end
endmodule
